cordic_scheduler: RTL and testbench
===================================

Name: cordic_scheduler

Overview:
- Round-robin scheduler that shares one iterative CORDIC sine/cosine core among N_REQ requesters.
- Accepts angle requests on per-requester valid/ready ports.
- Sequences the core's init/done protocol, captures results on the first done cycle, and returns them on one shared response channel tagged with the requester ID.
- Rejects out-of-range angles without running the core.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of rsp_id; must satisfy 2^ID_W >= N_REQ
- HALF_PI, 18'h1921F, largest legal |angle|, signed Q2.16 (pi/2)
- TIMEOUT, 64, RUN-state cycle limit; used only with CORDIC_SCHED_TIMEOUT_EN

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept, one-hot or zero
- req_angle  in  18*N_REQ  packed signed Q2.16 angles; slice k = bits [18k+17:18k]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  index of the requester being answered
- rsp_cos  out  18  signed Q2.16 cosine
- rsp_sin  out  18  signed Q2.16 sine
- rsp_err  out  1  1 = angle out of range (or timeout); cos and sin are 0
- core_init  out  1  core init/hold, active high
- core_angle  out  18  registered angle driven to the core
- core_done  in  1  core done flag
- core_cos  in  18  core cosine
- core_sin  in  18  core sine

Behaviour:
- Reset (rst_n=0, async) clears all registers:
  - state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_cos=0, rsp_sin=0, rsp_err=0, core_angle=0
  - core_init=1
  - req_ready=0 while in reset
- Release from reset is synchronous to clk.
- States: IDLE, INIT, RUN, RESP.
- IDLE:
  - Grant g = first index with req_valid set, searching from rr_ptr upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle; the handshake completes that cycle.
  - Register core_angle=req_angle[g] and rsp_id=g.
  - If |angle| > HALF_PI: next state RESP with rsp_err=1, rsp_cos=0, rsp_sin=0, rsp_valid=1. The core is not started.
  - Otherwise: next state INIT.
  - No req_valid: stay in IDLE with core_init=1.
- INIT: core_init=1 for exactly one cycle, then go to RUN.
- RUN:
  - core_init=0.
  - On the first cycle core_done=1: register rsp_cos=core_cos, rsp_sin=core_sin, rsp_err=0, rsp_valid=1; drive core_init=1 from the next cycle; go to RESP.
  - Core outputs are not guaranteed stable after the first done cycle. The capture happens only on that edge.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 && rsp_ready=0.
  - On rsp_ready=1: rsp_valid=0, rr_ptr=(g+1) mod N_REQ, go to IDLE.
  - core_init=1 throughout.
- req_ready is 0 in INIT, RUN and RESP.
- No new grant is issued in the RESP cycle where rsp_ready is accepted; the earliest next grant is the following cycle.
- Requesters must hold req_valid and req_angle until accepted. A requester that drops req_valid before grant is simply skipped.
- Latency: grant -> rsp_valid = 2 + core latency (nominal core latency 16, so 18 cycles). Error path: grant -> rsp_valid = 1 cycle.
- Fairness: every requester with valid held is served within N_REQ grants.
- Range check uses 18-bit signed compare. angle = -2^17 is out of range (magnitude saturates).
- rst_n asserted mid-RUN or mid-RESP aborts the operation silently. No response is issued.

Optional Feature:
- Macro: CORDIC_SCHED_TIMEOUT_EN
- Defined:
  - A cycle counter runs in RUN.
  - If core_done has not been seen after TIMEOUT cycles: go to RESP with rsp_err=1, rsp_cos=0, rsp_sin=0; core_init=1.
  - The counter clears on entry to RUN.
- Undefined: RUN waits indefinitely; no counter logic is present.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, rsp_valid=0, core_init=1. Deassert -> first grant goes to requester 0.
- Single request: req 1, angle 0x0860B (pi/6) -> rsp_valid within 18 cycles, rsp_id=1, rsp_err=0, rsp_sin=0x08000 ±16 LSB, rsp_cos=0x0DDB4 ±16 LSB.
- Round-robin: all 4 req_valid held, angles 0, 0x0860B, 0x10C15, 0x1921F, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0. Angle 0 gives cos 0x10000 ±16, sin 0 ±16.
- Out of range: req 2, angle 0x1A000 -> rsp_valid 1 cycle after grant, rsp_err=1, cos=sin=0; core_init stays 1 throughout.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable, req_ready=0, no new grant. rsp_ready=1 -> next grant the following cycle.
- Timeout (macro defined, core_done tied 0): rsp_err=1 exactly TIMEOUT=64 cycles after RUN entry. Separately, rst_n pulse mid-RUN -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cordic_scheduler.sv
// Round-robin scheduler sharing one iterative CORDIC sin/cos core among N_REQ requesters.
// Optional RUN-state watchdog: define CORDIC_SCHED_TIMEOUT_EN to enable it.

module cordic_scheduler #(
    parameter int                 N_REQ   = 4,
    parameter int                 ID_W    = 2,
    parameter logic signed [17:0] HALF_PI = 18'sh1921F,
    parameter int                 TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [18*N_REQ-1:0]   req_angle,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [17:0]           rsp_cos,
    output logic [17:0]           rsp_sin,
    output logic                  rsp_err,
    output logic                  core_init,
    output logic [17:0]           core_angle,
    input  logic                  core_done,
    input  logic [17:0]           core_cos,
    input  logic [17:0]           core_sin
);

    if (N_REQ < 2 || N_REQ > 8 || (1 << ID_W) < N_REQ || TIMEOUT < 1) begin : g_bad_params
        $error("cordic_scheduler: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, INIT, RUN, RESP} state_e;

    localparam logic signed [17:0] NEG_HALF_PI = -HALF_PI;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [17:0]     core_angle_q, core_angle_d;
    logic [17:0]     rsp_cos_q, rsp_cos_d;
    logic [17:0]     rsp_sin_q, rsp_sin_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`endif

    logic [17:0]        angle_arr [N_REQ];
    logic               grant_vld;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand;
    logic signed [17:0] grant_angle;
    logic               angle_oor;

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            angle_arr[k] = req_angle[18*k +: 18];
        end
    end

    // First valid requester at or after rr_ptr, wrapping at N_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
            cand = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + ID_W'(1);
        end
    end

    assign grant_angle = $signed(angle_arr[grant_idx]);
    assign angle_oor   = (grant_angle > HALF_PI) || (grant_angle < NEG_HALF_PI);

    // req_ready is decoded from state, so it is explicitly masked while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == IDLE && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // NOTE: every variable gets its default before the case; a missed branch would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        rsp_id_d     = rsp_id_q;
        core_angle_d = core_angle_q;
        rsp_cos_d    = rsp_cos_q;
        rsp_sin_d    = rsp_sin_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
`ifdef CORDIC_SCHED_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    core_angle_d = angle_arr[grant_idx];
                    rsp_id_d     = grant_idx;
                    if (angle_oor) begin
                        rsp_err_d   = 1'b1;
                        rsp_cos_d   = '0;
                        rsp_sin_d   = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        state_d = INIT;
                    end
                end
            end
            INIT: begin
`ifdef CORDIC_SCHED_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                state_d = RUN;
            end
            RUN: begin
                // Core outputs are only trustworthy on the first done cycle.
                if (core_done) begin
                    rsp_cos_d   = core_cos;
                    rsp_sin_d   = core_sin;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
`ifdef CORDIC_SCHED_TIMEOUT_EN
                else if (to_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_cos_d   = '0;
                    rsp_sin_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    to_cnt_d = to_cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (rsp_id_q == ID_W'(N_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            rsp_id_q     <= '0;
            core_angle_q <= '0;
            rsp_cos_q    <= '0;
            rsp_sin_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_id_q     <= rsp_id_d;
            core_angle_q <= core_angle_d;
            rsp_cos_q    <= rsp_cos_d;
            rsp_sin_q    <= rsp_sin_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
`ifdef CORDIC_SCHED_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    // Core is held in init everywhere except RUN, which also covers reset.
    assign core_init  = (state_q != RUN);
    assign core_angle = core_angle_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_cos    = rsp_cos_q;
    assign rsp_sin    = rsp_sin_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Scoreboard bench for cordic_scheduler: directed requests push expected responses,
// a monitor pops and compares them; a behavioural core model answers after 16 cycles.

module tb_cordic_scheduler;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int CORE_LAT = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [N_REQ-1:0]      req_valid = '0;
    logic [N_REQ-1:0]      req_ready;
    logic [18*N_REQ-1:0]   req_angle = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [ID_W-1:0]       rsp_id;
    logic [17:0]           rsp_cos, rsp_sin;
    logic                  rsp_err;
    logic                  core_init;
    logic [17:0]           core_angle;
    logic                  core_done;
    logic [17:0]           core_cos, core_sin;

    cordic_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .HALF_PI(18'sh1921F), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_angle(req_angle),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_err(rsp_err),
        .core_init(core_init), .core_angle(core_angle), .core_done(core_done),
        .core_cos(core_cos), .core_sin(core_sin)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: done in the 16th cycle after init drops, slightly noisy results, junk otherwise.
    int core_cnt = 0;
    bit core_hang = 1'b0;
    always @(posedge clk) core_cnt <= core_init ? 0 : core_cnt + 1;

    function automatic logic [35:0] core_table(input logic [17:0] a);
        case (a)
            18'h00000: return {18'h10000, 18'h00000};
            18'h0860B: return {18'h0DDB4, 18'h08000};
            18'h10C15: return {18'h08000, 18'h0DDB4};
            18'h1921F: return {18'h00000, 18'h10000};
            18'h26DE1: return {18'h00000, 18'h30000};
            18'h379F5: return {18'h0DDB4, 18'h38000};
            default:   return 36'h0;
        endcase
    endfunction

    logic [35:0] core_cs;
    always_comb begin
        core_cs   = core_table(core_angle);
        core_done = !core_init && !core_hang && (core_cnt == CORE_LAT - 1);
        core_cos  = 18'h2AAAA;
        core_sin  = 18'h15555;
        if (core_done) begin
            core_cos = core_cs[35:18] + 18'd2;
            core_sin = core_cs[17:0] - 18'd1;
        end
    end

    typedef struct {
        logic [ID_W-1:0] id;
        logic            err;
        logic [17:0]     cos;
        logic [17:0]     sin;
        int              lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   grant_cyc = 0;
    int   grant_cnt = 0;
    int   ci_low = 0;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic bit near(input logic [17:0] a, input logic [17:0] e, input int tol);
        int d;
        d = int'($signed(a)) - int'($signed(e));
        return (d <= tol) && (d >= -tol);
    endfunction

    task automatic push(input int id, input bit err, input logic [17:0] c, input logic [17:0] s, input int lat);
        exp_t e;
        e.id = ID_W'(id); e.err = err; e.cos = c; e.sin = s; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic set_angle(input int k, input logic [17:0] a);
        req_angle[18*k +: 18] = a;
    endtask

    // Monitor: grant bookkeeping, hold stability, latency and response scoreboard.
    logic            prev_valid = 1'b0, prev_hold = 1'b0;
    logic [ID_W-1:0] p_id;
    logic            p_err;
    logic [17:0]     p_cos, p_sin;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            if (!core_init) ci_low++;
            if (|(req_ready & req_valid)) begin
                grant_cyc = cyc;
                grant_cnt++;
                check("grant_onehot", $onehot(req_ready), 32'(req_ready), 32'(req_valid));
            end
            if (prev_hold) begin
                check("hold_data", rsp_id == p_id && rsp_err == p_err && rsp_cos == p_cos && rsp_sin == p_sin,
                      {rsp_cos, 14'(rsp_sin)}, {p_cos, 14'(p_sin)});
                check("hold_no_grant", rsp_valid && req_ready == '0, {27'd0, rsp_valid, req_ready}, 32'h10);
            end
            if (rsp_valid && !prev_valid) begin
                if (exp_q.size() == 0)
                    check("unexpected_rsp", 1'b0, 32'(rsp_id), 32'hFFFF_FFFF);
                else
                    check("latency", (cyc - grant_cyc) == exp_q[0].lat, cyc - grant_cyc, exp_q[0].lat);
            end
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                exp_t e;
                int   tol;
                e   = exp_q.pop_front();
                tol = e.err ? 0 : 16;
                check("rsp_id",  rsp_id == e.id,   32'(rsp_id),  32'(e.id));
                check("rsp_err", rsp_err == e.err, 32'(rsp_err), 32'(e.err));
                check("rsp_cos", near(rsp_cos, e.cos, tol), 32'(rsp_cos), 32'(e.cos));
                check("rsp_sin", near(rsp_sin, e.sin, tol), 32'(rsp_sin), 32'(e.sin));
            end
            prev_valid = rsp_valid;
            prev_hold  = rsp_valid && !rsp_ready;
            p_id = rsp_id; p_err = rsp_err; p_cos = rsp_cos; p_sin = rsp_sin;
        end
    end

    // Raise the requesters in mask and wait for n grants; non-kept requesters drop after their grant.
    task automatic drive(input logic [N_REQ-1:0] mask, input int n, input bit keep);
        int got;
        int budget;
        logic [N_REQ-1:0] g;
        got = 0;
        budget = 300 * n;
        req_valid = mask;
        while (got < n && budget > 0) begin
            @(negedge clk);
            budget--;
            g = req_ready & req_valid;
            if (|g) begin
                got++;
                @(posedge clk); #1;
                if (!keep) req_valid = req_valid & ~g;
            end
        end
        if (got < n) check("grant_timeout", 1'b0, got, n);
        req_valid = '0;
    endtask

    task automatic wait_drain();
        int b;
        for (b = 0; b < 300; b++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) break;
        end
        if (b == 300) check("drain_timeout", 1'b0, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    typedef struct { int id; logic [17:0] ang; bit err; logic [17:0] c; logic [17:0] s; } vec_t;
    vec_t vecs[5] = '{
        '{2, 18'h1A000, 1'b1, 18'h00000, 18'h00000},
        '{3, 18'h20000, 1'b1, 18'h00000, 18'h00000},
        '{0, 18'h19220, 1'b1, 18'h00000, 18'h00000},
        '{1, 18'h26DE1, 1'b0, 18'h00000, 18'h30000},
        '{2, 18'h26DE0, 1'b1, 18'h00000, 18'h00000}
    };

    initial begin
        int c0;
        int acc;
        int gc0;
        int b;

        // Reset with every requester asking.
        #3 rst_n = 1'b0;
        req_valid = '1;
        #1;
        check("rst_req_ready", req_ready == '0, 32'(req_ready), 0);
        check("rst_rsp_valid", rsp_valid == 1'b0, 32'(rsp_valid), 0);
        check("rst_core_init", core_init == 1'b1, 32'(core_init), 1);
        check("rst_rsp_id", rsp_id == '0, 32'(rsp_id), 0);
        check("rst_rsp_data", {rsp_err, rsp_cos, rsp_sin} == '0, 32'(rsp_cos), 0);
        check("rst_core_angle", core_angle == '0, 32'(core_angle), 0);

        // Round-robin sweep, first grant after reset goes to requester 0.
        set_angle(0, 18'h00000); set_angle(1, 18'h0860B);
        set_angle(2, 18'h10C15); set_angle(3, 18'h1921F);
        push(0, 0, 18'h10000, 18'h00000, 18);
        push(1, 0, 18'h0DDB4, 18'h08000, 18);
        push(2, 0, 18'h08000, 18'h0DDB4, 18);
        push(3, 0, 18'h00000, 18'h10000, 18);
        push(0, 0, 18'h10000, 18'h00000, 18);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive('1, 5, 1'b1);
        wait_drain();

        // Single request, pi/6.
        set_angle(1, 18'h0860B);
        push(1, 0, 18'h0DDB4, 18'h08000, 18);
        drive(4'b0010, 1, 1'b0);
        wait_drain();

        // Range boundaries: core must stay in init for rejected angles.
        foreach (vecs[i]) begin
            set_angle(vecs[i].id, vecs[i].ang);
            push(vecs[i].id, vecs[i].err, vecs[i].c, vecs[i].s, vecs[i].err ? 1 : 18);
            c0 = ci_low;
            drive(4'(1 << vecs[i].id), 1, 1'b0);
            wait_drain();
            check("core_run_cycles", (ci_low - c0) == (vecs[i].err ? 0 : CORE_LAT), ci_low - c0,
                  vecs[i].err ? 0 : CORE_LAT);
        end

        // Backpressure: response held 10 cycles while requester 0 waits.
        set_angle(3, 18'h10C15);
        set_angle(0, 18'h00000);
        push(3, 0, 18'h08000, 18'h0DDB4, 18);
        push(0, 0, 18'h10000, 18'h00000, 18);
        rsp_ready = 1'b0;
        drive(4'b1000, 1, 1'b0);
        for (b = 0; b < 100; b++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        check("bp_rsp_seen", b < 100, b, 100);
        @(posedge clk); #1;
        req_valid = 4'b0001;
        repeat (10) @(posedge clk);
        #1 rsp_ready = 1'b1;
        acc = cyc;
        gc0 = grant_cnt;
        for (b = 0; b < 50; b++) begin
            @(posedge clk);
            if (grant_cnt != gc0) break;
        end
        check("bp_next_grant_cycle", grant_cyc == acc + 1, grant_cyc, acc + 1);
        #1 req_valid = '0;
        wait_drain();

`ifdef CORDIC_SCHED_TIMEOUT_EN
        // Hung core: error response 64 cycles after RUN entry.
        core_hang = 1'b1;
        set_angle(2, 18'h0860B);
        push(2, 1, 18'h00000, 18'h00000, 66);
        c0 = ci_low;
        drive(4'b0100, 1, 1'b0);
        wait_drain();
        check("timeout_run_cycles", (ci_low - c0) == 64, ci_low - c0, 64);
        core_hang = 1'b0;
`endif

        // Requester 2 served last, leaving the pointer at 3.
        set_angle(2, 18'h0860B);
        push(2, 0, 18'h0DDB4, 18'h08000, 18);
        drive(4'b0100, 1, 1'b0);
        wait_drain();

        // Reset mid-RUN aborts silently and clears the pointer.
        set_angle(2, 18'h00000);
        drive(4'b0100, 1, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        check("pre_reset_in_run", core_init == 1'b0, 32'(core_init), 0);
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", rsp_valid == 1'b0, 32'(rsp_valid), 0);
        check("mid_rst_core_init", core_init == 1'b1, 32'(core_init), 1);
        check("mid_rst_req_ready", req_ready == '0, 32'(req_ready), 0);
        check("mid_rst_core_angle", core_angle == '0, 32'(core_angle), 0);
        check("mid_rst_rsp_id", rsp_id == '0, 32'(rsp_id), 0);
        @(posedge clk); #1 req_valid = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        set_angle(1, 18'h0860B);
        set_angle(3, 18'h379F5);
        push(1, 0, 18'h0DDB4, 18'h08000, 18);
        push(3, 0, 18'h0DDB4, 18'h38000, 18);
        drive(4'b1010, 2, 1'b0);
        wait_drain();

        check("queue_empty", exp_q.size() == 0, exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1);
    end

endmodule
